// File: rtl/lane_shift_pkg.sv
// Shared types for lane_shift_seq: FSM state encoding and per-lane shift mode encoding.
package lane_shift_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ModeSll = 3'd0,
        ModeSrl = 3'd1,
        ModeSra = 3'd2,
        ModeRol = 3'd3,
        ModeRor = 3'd4
    } shift_mode_e;

    // Rotate wins over arith; arith only matters for right shifts.
    function automatic shift_mode_e decode_mode(input logic dir, input logic arith,
                                                input logic rot);
        if (rot) begin
            return dir ? ModeRor : ModeRol;
        end
        if (!dir) begin
            return ModeSll;
        end
        return arith ? ModeSra : ModeSrl;
    endfunction

endpackage

// File: rtl/lane_shift_seq_if.sv
// Request/result bundle for lane_shift_seq; slave is the shifter, master the requester.
interface lane_shift_seq_if #(
    parameter int unsigned LANES = 2,
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned AW = $clog2(WIDTH);
    localparam int unsigned DW = LANES * WIDTH;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a_in;
    logic [AW-1:0] amt;
    logic          dir;
    logic          arith;
    logic          rot;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] y;
    logic          busy;

    modport master (
        output in_valid, a_in, amt, dir, arith, rot, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, a_in, amt, dir, arith, rot, out_ready,
        output in_ready, out_valid, y, busy
    );

endinterface

// File: rtl/lane_shift_step.sv
// One lane, one-bit combinational shift step. Rotate cases exist only with LANE_SHIFT_ROTATE_EN.
module lane_shift_step
    import lane_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (mode)
            ModeSll: y = {a[WIDTH-2:0], 1'b0};
            ModeSrl: y = {1'b0, a[WIDTH-1:1]};
            ModeSra: y = {a[WIDTH-1], a[WIDTH-1:1]};
`ifdef LANE_SHIFT_ROTATE_EN
            ModeRol: y = {a[WIDTH-2:0], a[WIDTH-1]};
            ModeRor: y = {a[0], a[WIDTH-1:1]};
`endif
            default: y = a;
        endcase
    end

endmodule

// File: rtl/lane_shift_seq.sv
// Multi-lane sequential shifter: one bit per cycle per lane, result held until consumed.
// Rotation is built only when LANE_SHIFT_ROTATE_EN is defined; otherwise rot is ignored.
module lane_shift_seq
    import lane_shift_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    lane_shift_seq_if.slave bus
);

    localparam int unsigned AW = $clog2(WIDTH);
    localparam int unsigned DW = LANES * WIDTH;

    state_e        state_q, state_d;
    logic [DW-1:0] y_q, y_d, step_y;
    logic [AW-1:0] cnt_q, cnt_d;
    shift_mode_e   mode_q, mode_d;
    logic          rot_en;
    logic          accept;

`ifdef LANE_SHIFT_ROTATE_EN
    assign rot_en = bus.rot;
`else
    assign rot_en = 1'b0;
`endif

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.y         = y_q;
    assign accept        = bus.in_valid && bus.in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_shift_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .a   (y_q[i*WIDTH +: WIDTH]),
            .mode(mode_q),
            .y   (step_y[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            y_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= ModeSll;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    y_d     = bus.a_in;
                    cnt_d   = bus.amt;
                    mode_d  = decode_mode(bus.dir, bus.arith, rot_en);
                    state_d = (bus.amt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                y_d   = step_y;
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
